// File: rtl/prim_sequencer_if.sv
// Control, vertex-RAM and line-engine signals of the primitive sequencer.
// The master side drives requests and RAM data; the slave side is the sequencer.
interface prim_sequencer_if #(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 32
);
    logic                  go;
    logic                  load_finish;
    logic                  abort;
    logic [addr_width-1:0] prim_count;
    logic [addr_width-1:0] ram_read_addr;
    logic [data_width-1:0] ram_read_data1;
    logic [data_width-1:0] ram_read_data2;
    logic [data_width-1:0] ram_read_data3;
    logic [data_width-1:0] ram_read_data4;
    logic [data_width-1:0] draw_x0;
    logic [data_width-1:0] draw_y0;
    logic [data_width-1:0] draw_x1;
    logic [data_width-1:0] draw_y1;
    logic                  draw_start;
    logic                  draw_done;
    logic                  busy;
    logic                  seq_done;
    logic [addr_width-1:0] prim_index;

    modport master (
        output go, load_finish, abort, prim_count,
        output ram_read_data1, ram_read_data2, ram_read_data3, ram_read_data4,
        output draw_done,
        input  ram_read_addr, draw_x0, draw_y0, draw_x1, draw_y1,
        input  draw_start, busy, seq_done, prim_index
    );

    modport slave (
        input  go, load_finish, abort, prim_count,
        input  ram_read_data1, ram_read_data2, ram_read_data3, ram_read_data4,
        input  draw_done,
        output ram_read_addr, draw_x0, draw_y0, draw_x1, draw_y1,
        output draw_start, busy, seq_done, prim_index
    );
endinterface

// File: rtl/prim_sequencer.sv
// Walks the primitive list in vertex RAM, latching each record and launching
// the line engine once per primitive, waiting for its completion in between.
module prim_sequencer #(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 32
) (
    input  logic             clk,
    input  logic             reset,
    prim_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [addr_width-1:0] prim_index_q, prim_index_d;
    logic [addr_width-1:0] ram_read_addr_q;
    logic [data_width-1:0] draw_x0_q, draw_y0_q, draw_x1_q, draw_y1_q;
    logic                  draw_start_q, busy_q, seq_done_q;
    logic                  busy_now_c, busy_next_c, addr_phase_c;

    // Next-state and index update; abort overrides every busy-state transition
    always_comb begin
        state_d      = state_q;
        prim_index_d = prim_index_q;
        busy_now_c   = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                       (state_q == S_ISSUE) || (state_q == S_WAIT);
        case (state_q)
            S_IDLE: begin
                if (bus.go && bus.load_finish) begin
                    prim_index_d = '0;
                    state_d      = (bus.prim_count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.draw_done) begin
                    if (prim_index_q == bus.prim_count - addr_width'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        prim_index_d = prim_index_q + addr_width'(1);
                        state_d      = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (!bus.go) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort && busy_now_c) begin
            state_d      = S_IDLE;
            prim_index_d = prim_index_q;
        end
        busy_next_c  = (state_d == S_FETCH) || (state_d == S_LATCH) ||
                       (state_d == S_ISSUE) || (state_d == S_WAIT);
        addr_phase_c = (state_d == S_FETCH) || (state_d == S_LATCH);
    end

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            prim_index_q    <= '0;
            ram_read_addr_q <= '0;
            draw_x0_q       <= '0;
            draw_y0_q       <= '0;
            draw_x1_q       <= '0;
            draw_y1_q       <= '0;
            draw_start_q    <= 1'b0;
            busy_q          <= 1'b0;
            seq_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            prim_index_q    <= prim_index_d;
            ram_read_addr_q <= addr_phase_c ? prim_index_d : '0;
            draw_start_q    <= (state_d == S_ISSUE);
            busy_q          <= busy_next_c;
            seq_done_q      <= (state_d == S_DONE);
            if (state_q == S_LATCH) begin
                draw_x0_q <= bus.ram_read_data1;
                draw_y0_q <= bus.ram_read_data2;
                draw_x1_q <= bus.ram_read_data3;
                draw_y1_q <= bus.ram_read_data4;
            end
        end
    end

    assign bus.ram_read_addr = ram_read_addr_q;
    assign bus.prim_index    = prim_index_q;
    assign bus.draw_x0       = draw_x0_q;
    assign bus.draw_y0       = draw_y0_q;
    assign bus.draw_x1       = draw_x1_q;
    assign bus.draw_y1       = draw_y1_q;
    assign bus.draw_start    = draw_start_q;
    assign bus.busy          = busy_q;
    assign bus.seq_done      = seq_done_q;

endmodule
